// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces presses and releases, and encodes
// accepted keys into the calculator front-end protocol (digit level, operator code, '=' pulse).
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   input  logic       complete,
   output logic [3:0] col_n,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] keypad_input,
   output logic [1:0] operator_code,
   output logic       equal_input
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hD;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hE;
         default: code = 4'hF;
      endcase
      return code;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [3:0]        row_meta_r, row_sync_r, low_s;
   logic [SLOT_W-1:0] slot_r;
   logic [1:0]        col_r, row_r, low_row_s;
   logic [3:0]        col_n_r;
   logic [CNT_W-1:0]  deb_cnt_r, rel_cnt_r;
   logic              sample_s, any_low_s, match_s, row_high_s;
   logic              capture_s, accept_s, release_s, advance_s;
   logic [3:0]        code_s;
   logic              key_valid_r, equal_input_r;
   logic [3:0]        key_code_r, keypad_input_r;
   logic [1:0]        operator_code_r;

   assign sample_s = (slot_r == SLOT_LAST);
   assign code_s   = key_lookup(row_r, col_r);

   // two-flop synchronizer for the asynchronous row inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta_r <= 4'hF;
         row_sync_r <= 4'hF;
      end else begin
         row_meta_r <= row_n;
         row_sync_r <= row_meta_r;
      end
   end

   // row decode: lowest pressed row wins within the driven column
   always_comb begin
      low_s     = ~row_sync_r;
      any_low_s = |low_s;
      if (low_s[0]) begin
         low_row_s = 2'd0;
      end else if (low_s[1]) begin
         low_row_s = 2'd1;
      end else if (low_s[2]) begin
         low_row_s = 2'd2;
      end else begin
         low_row_s = 2'd3;
      end
      match_s    = any_low_s && (low_row_s == row_r);
      row_high_s = row_sync_r[row_r];
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_SCAN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state logic; every decision is taken only at a slot's sample point
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_SCAN: begin
            if (sample_s && any_low_s) begin
               state_nxt_s = ST_DEBOUNCE;
            end else begin
               state_nxt_s = ST_SCAN;
            end
         end
         ST_DEBOUNCE: begin
            if (sample_s && !match_s) begin
               state_nxt_s = ST_SCAN;
            end else if (sample_s && (deb_cnt_r >= CNT_LAST)) begin
               state_nxt_s = ST_HELD;
            end else begin
               state_nxt_s = ST_DEBOUNCE;
            end
         end
         ST_HELD: begin
            if (sample_s && row_high_s && (rel_cnt_r >= CNT_LAST)) begin
               state_nxt_s = ST_SCAN;
            end else begin
               state_nxt_s = ST_HELD;
            end
         end
         default: state_nxt_s = ST_SCAN;
      endcase
   end

   // per-state strobes driving the counters and the registered outputs
   always_comb begin
      capture_s = 1'b0;
      accept_s  = 1'b0;
      release_s = 1'b0;
      advance_s = 1'b0;
      case (state_r)
         ST_SCAN: begin
            capture_s = sample_s && any_low_s;
            advance_s = sample_s && !any_low_s;
         end
         ST_DEBOUNCE: begin
            accept_s  = (state_nxt_s == ST_HELD);
            advance_s = sample_s && !match_s;
         end
         ST_HELD: begin
            release_s = (state_nxt_s == ST_SCAN);
            advance_s = (state_nxt_s == ST_SCAN);
         end
         default: begin
            capture_s = 1'b0;
            advance_s = 1'b0;
         end
      endcase
   end

   // slot timer, column rotation, captured row and saturating debounce counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_r    <= SLOT_ZERO;
         col_r     <= 2'd0;
         col_n_r   <= 4'b1110;
         row_r     <= 2'd0;
         deb_cnt_r <= CNT_ZERO;
         rel_cnt_r <= CNT_ZERO;
      end else begin
         slot_r <= sample_s ? SLOT_ZERO : (slot_r + SLOT_ONE);
         if (advance_s) begin
            col_r   <= col_r + 2'd1;
            col_n_r <= {col_n_r[2:0], col_n_r[3]};
         end
         if (capture_s) begin
            row_r <= low_row_s;
         end
         case (state_r)
            ST_SCAN: begin
               deb_cnt_r <= capture_s ? CNT_ONE : CNT_ZERO;
               rel_cnt_r <= CNT_ZERO;
            end
            ST_DEBOUNCE: begin
               if (sample_s && match_s && (deb_cnt_r < CNT_MAX)) begin
                  deb_cnt_r <= deb_cnt_r + CNT_ONE;
               end
               rel_cnt_r <= CNT_ZERO;
            end
            ST_HELD: begin
               deb_cnt_r <= CNT_ZERO;
               if (sample_s && !row_high_s) begin
                  rel_cnt_r <= CNT_ZERO;
               end else if (sample_s && (rel_cnt_r < CNT_MAX)) begin
                  rel_cnt_r <= rel_cnt_r + CNT_ONE;
               end
            end
            default: begin
               deb_cnt_r <= CNT_ZERO;
               rel_cnt_r <= CNT_ZERO;
            end
         endcase
      end
   end

   // front-end outputs; the unused key F debounces but is never reported
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_valid_r     <= 1'b0;
         key_code_r      <= 4'h0;
         keypad_input_r  <= 4'h0;
         operator_code_r <= 2'b11;
         equal_input_r   <= 1'b0;
      end else begin
         key_valid_r   <= accept_s && (code_s != 4'hF);
         equal_input_r <= accept_s && (code_s == 4'hE);
         if (accept_s && (code_s != 4'hF)) begin
            key_code_r <= code_s;
         end
         if (accept_s) begin
            keypad_input_r <= ((code_s >= 4'h1) && (code_s <= 4'h9)) ? code_s : 4'h0;
         end else if (release_s) begin
            keypad_input_r <= 4'h0;
         end
         if (accept_s && (code_s == 4'hA)) begin
            operator_code_r <= 2'b00;
         end else if (accept_s && (code_s == 4'hB)) begin
            operator_code_r <= 2'b01;
         end else if (accept_s && (code_s == 4'hC)) begin
            operator_code_r <= 2'b10;
         end else if ((accept_s && (code_s == 4'hD)) || complete) begin
            operator_code_r <= 2'b11;
         end
      end
   end

   assign col_n         = col_n_r;
   assign key_valid     = key_valid_r;
   assign key_code      = key_code_r;
   assign keypad_input  = keypad_input_r;
   assign operator_code = operator_code_r;
   assign equal_input   = equal_input_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled key matrix into keypad_scanner and checks every cycle
// against a sample-level behavioural model, plus literal expectations for each scenario.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DS = 3;

   logic       clk;
   logic       reset = 1'b1;
   logic       complete = 1'b0;
   logic [15:0] pressed = 16'h0000;
   logic [3:0] row_n;
   logic [3:0] col_n, key_code, keypad_input;
   logic       key_valid, equal_input;
   logic [1:0] operator_code;

   int n_vec = 0;
   int n_miss = 0;
   int kv_cnt = 0;
   int eq_cnt = 0;
   int kv0, eq0;

   // model state: sample-level view of the scanner
   int m_edges, m_mode, m_col, m_row, m_cnt, m_rel;
   logic [3:0] m_d1, m_d2;
   logic       e_kv, e_eq;
   logic [3:0] e_code, e_kin;
   logic [1:0] e_op;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .reset(reset), .row_n(row_n), .complete(complete),
      .col_n(col_n), .key_valid(key_valid), .key_code(key_code),
      .keypad_input(keypad_input), .operator_code(operator_code), .equal_input(equal_input)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // physical matrix: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   function automatic logic [3:0] model_code(input int r, input int c);
      if (r < 3 && c < 3) return 4'(r * 3 + c + 1);
      if (c == 3 && r < 3) return 4'(10 + r);
      if (c == 0) return 4'hD;
      if (c == 1) return 4'h0;
      if (c == 2) return 4'hE;
      return 4'hF;
   endfunction

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_init();
      m_edges = 0; m_mode = 0; m_col = 0; m_row = 0; m_cnt = 0; m_rel = 0;
      m_d1 = 4'h0; m_d2 = 4'h0;
      e_kv = 1'b0; e_eq = 1'b0; e_code = 4'h0; e_kin = 4'h0; e_op = 2'b11;
   endtask

   task automatic model_accept(input logic [3:0] code);
      if (code == 4'hF) begin
         e_kin = 4'h0;
      end else begin
         e_kv = 1'b1;
         e_code = code;
         e_kin = (code >= 4'h1 && code <= 4'h9) ? code : 4'h0;
         if (code == 4'hA) e_op = 2'b00;
         if (code == 4'hB) e_op = 2'b01;
         if (code == 4'hC) e_op = 2'b10;
         if (code == 4'hD) e_op = 2'b11;
         if (code == 4'hE) e_eq = 1'b1;
      end
   endtask

   task automatic model_step();
      logic [3:0] now, seen;
      int low;
      now = 4'h0;
      for (int r = 0; r < 4; r++) if (pressed[r*4+m_col]) now[r] = 1'b1;
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = now;
      m_edges++;
      e_kv = 1'b0;
      e_eq = 1'b0;
      if (complete) e_op = 2'b11;
      if (m_edges % SD == 0) begin
         low = -1;
         for (int r = 3; r >= 0; r--) if (seen[r]) low = r;
         if (m_mode == 0) begin
            if (low >= 0) begin
               m_row = low; m_cnt = 1; m_mode = 1;
            end else begin
               m_col = (m_col + 1) % 4;
            end
         end else if (m_mode == 1) begin
            if (low == m_row) begin
               m_cnt++;
               if (m_cnt >= DS) begin
                  m_mode = 2; m_rel = 0;
                  model_accept(model_code(m_row, m_col));
               end
            end else begin
               m_mode = 0; m_col = (m_col + 1) % 4;
            end
         end else begin
            if (seen[m_row]) begin
               m_rel = 0;
            end else begin
               m_rel++;
               if (m_rel >= DS) begin
                  m_mode = 0; e_kin = 4'h0; m_col = (m_col + 1) % 4;
               end
            end
         end
      end
   endtask

   // model advances on each active edge, or resets asynchronously
   initial begin
      model_init();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_init();
         else model_step();
      end
   end

   // per-cycle comparison of every output against the model
   initial begin
      logic [3:0] one_hot;
      @(posedge clk);
      forever begin
         @(negedge clk);
         one_hot = 4'b0001 << m_col;
         check("col_n", col_n, ~one_hot);
         check("key_valid", 4'(key_valid), 4'(e_kv));
         check("key_code", key_code, e_code);
         check("keypad_input", keypad_input, e_kin);
         check("operator_code", 4'(operator_code), 4'(e_op));
         check("equal_input", 4'(equal_input), 4'(e_eq));
         if (key_valid) kv_cnt++;
         if (equal_input) eq_cnt++;
      end
   end

   task automatic tap(input int idx, input int hold, input int gap);
      @(negedge clk);
      pressed[idx] = 1'b1;
      repeat (hold) @(negedge clk);
      pressed[idx] = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("col_after_first_slot", col_n, 4'b1101);
      // asynchronous reset mid-scan
      #2 reset = 1'b1;
      #1;
      check("rst_col_n", col_n, 4'b1110);
      check("rst_operator", 4'(operator_code), 4'b0011);
      check("rst_key_valid", 4'(key_valid), 4'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // steady '5'
      kv0 = kv_cnt;
      @(negedge clk);
      pressed[5] = 1'b1;
      repeat (60) @(negedge clk);
      check("hold5_keypad_input", keypad_input, 4'h5);
      pressed[5] = 1'b0;
      repeat (40) @(negedge clk);
      check("rel5_keypad_input", keypad_input, 4'h0);
      check("key5_code", key_code, 4'h5);
      check("key5_pulses", 4'(kv_cnt - kv0), 4'h1);

      // bouncing '7', phased so every sample lands in a released half-period
      for (int i = 0; i < 8 && (m_edges % SD) != 3; i++) @(negedge clk);
      kv0 = kv_cnt;
      repeat (8) begin
         pressed[8] = 1'b1;
         repeat (2) @(negedge clk);
         pressed[8] = 1'b0;
         repeat (2) @(negedge clk);
      end
      check("bounce7_no_pulse", 4'(kv_cnt - kv0), 4'h0);
      pressed[8] = 1'b1;
      repeat (60) @(negedge clk);
      pressed[8] = 1'b0;
      repeat (40) @(negedge clk);
      check("key7_pulses", 4'(kv_cnt - kv0), 4'h1);
      check("key7_code", key_code, 4'h7);

      // operators and complete
      tap(7, 50, 40);
      check("sub_operator", 4'(operator_code), 4'h1);
      @(negedge clk);
      complete = 1'b1;
      @(negedge clk);
      complete = 1'b0;
      check("complete_operator", 4'(operator_code), 4'h3);
      tap(11, 50, 40);
      check("mul_operator", 4'(operator_code), 4'h2);
      tap(12, 50, 40);
      check("clear_operator", 4'(operator_code), 4'h3);
      check("clear_code", key_code, 4'hD);

      // '=' held long, operator untouched
      tap(3, 50, 40);
      check("add_operator", 4'(operator_code), 4'h0);
      eq0 = eq_cnt;
      tap(14, 100, 40);
      check("equal_pulses", 4'(eq_cnt - eq0), 4'h1);
      check("equal_operator", 4'(operator_code), 4'h0);

      // '2' and '8' together in column 1
      @(negedge clk);
      pressed[1] = 1'b1;
      pressed[9] = 1'b1;
      repeat (60) @(negedge clk);
      check("dual_code", key_code, 4'h2);
      check("dual_keypad_input", keypad_input, 4'h2);
      pressed[1] = 1'b0;
      pressed[9] = 1'b0;
      repeat (40) @(negedge clk);

      // reset while '9' is debouncing
      kv0 = kv_cnt;
      pressed[10] = 1'b1;
      for (int i = 0; i < 100 && m_mode != 1; i++) @(negedge clk);
      check("reached_debounce", 4'(m_mode), 4'h1);
      #2 reset = 1'b1;
      pressed[10] = 1'b0;
      #1;
      check("deb_rst_key_valid", 4'(key_valid), 4'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("deb_rst_no_pulse", 4'(kv_cnt - kv0), 4'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
